pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
Program-counter and fetch-sequencing stage directly upstream of the instruction memory in the single-cycle fetch unit. It owns the PC register and drives the word address into the synchronous-read instruction memory, which returns data one clock later. It also tags each returned instruction with its PC and a valid bit. It handles sequential fetch, stall (hold), zero-bubble redirect (branch/jump target), halt/resume, and a sticky misaligned-target fault.

Parameters:
RESET_VECTOR, 32'h0000_0000, byte address loaded into the PC on reset; must be 4-byte aligned.
XLEN, 32, PC and target width.
IMEM_AW, 32, width of the imem_addr port; matches the instruction memory addr width.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
stall_i  input  1  hold the current fetch; the downstream stage is not ready.
redirect_valid_i  input  1  load a new fetch target this cycle.
redirect_target_i  input  XLEN  byte address of the new target.
halt_i  input  1  stop fetching (ecall/ebreak/end of program).
imem_addr_o  output  IMEM_AW  word index into the instruction memory, equal to byte address >> 2 and zero-extended; combinational.
if_pc_o  output  XLEN  byte PC of the instruction the memory presents this cycle.
if_valid_o  output  1  the memory's instruction output is a live, correctly-tagged instruction.
fault_o  output  1  sticky misaligned-redirect fault.
state_o  output  2  current FSM state, for debug and bench.

Behaviour:
- Registers:
  - pc: the next address to fetch.
  - if_pc: the address the memory sampled at the last edge.
  - if_valid.
  - state.
  - fault.
- Reset (async, immediate on rst high):
  - pc = RESET_VECTOR; if_pc = RESET_VECTOR; if_valid = 0; fault = 0; state = RUN.
  - imem_addr_o therefore shows RESET_VECTOR>>2 during reset.
- FSM states: RUN=2'd0, HALT=2'd1, FAULT=2'd2. The value 2'd3 is illegal; the FSM recovers to FAULT.
- Address mux (combinational), priority top-down:
  - state==FAULT -> pc>>2.
  - redirect_valid_i and target[1:0]==0 -> target>>2.
  - stall_i or state==HALT -> if_pc>>2. This re-reads the held instruction so the memory output stays stable.
  - otherwise -> pc>>2.
- Sequencing in RUN, per posedge, priority top-down:
  1. Redirect with target[1:0]!=0: state->FAULT, fault<=1, if_valid<=0, pc holds.
  2. Aligned redirect (overrides stall and halt_i): if_pc<=target, pc<=target+4, if_valid<=1. This is a zero-bubble redirect; the first target instruction is presented on the next cycle.
  3. halt_i: state->HALT, if_valid<=0, pc and if_pc hold.
  4. stall_i: pc, if_pc and if_valid all hold.
  5. Else: if_pc<=pc, pc<=pc+4, if_valid<=1.
- HALT state:
  - Only an aligned redirect leaves HALT; it applies the redirect action and goes to RUN.
  - A misaligned redirect goes to FAULT.
  - stall_i and halt_i are ignored.
- FAULT state:
  - All inputs are ignored and if_valid=0; only rst exits.
- Latency: the instruction for address A appears at the memory output one cycle after imem_addr_o=A; if_pc_o/if_valid_o are aligned with that output.
- First cycle after reset release: if_valid=0, since the memory output is undefined. Valid first rises at the first edge after rst falls.
- Arithmetic:
  - pc+4 is modulo 2^XLEN: 32'hFFFF_FFFC -> 32'h0000_0000, no flag.
  - imem_addr_o = {2'b00, addr[XLEN-1:2]} when IMEM_AW==XLEN.
- Wrong-path instruction: the instruction presented in the cycle a redirect is asserted is still marked valid. The downstream stage that raised the redirect squashes it.
- Reset mid-stall or mid-redirect: async reset wins and all state returns to reset values.

Decomposition:
- Shared package fetch_pkg holds:
  - the FSM state encodings (RUN/HALT/FAULT);
  - INSTR_BYTES=4;
  - RESET_VECTOR default.
- The next-PC/address priority mux is a natural sub-module, next_pc_mux (purely combinational). The FSM and registers stay in the top.

Test Plan:
- Reset release, no stalls, RESET_VECTOR=0 -> imem_addr_o 0,1,2,3 on successive cycles; if_pc_o 0,4,8 with if_valid_o=1 from cycle 1; if_valid_o=0 in cycle 0.
- stall_i high for 3 cycles while if_pc_o=0x8 -> imem_addr_o=2 throughout; if_pc_o stays 0x8, if_valid_o stays 1; after release, next if_pc_o=0xC.
- Redirect to 0x100 with stall_i also high -> same cycle imem_addr_o=0x40; next cycle if_pc_o=0x100, if_valid_o=1; following cycle if_pc_o=0x104.
- Redirect to 0x102 -> next cycle state_o=FAULT, fault_o=1, if_valid_o=0; a later aligned redirect to 0x0 leaves fault_o=1 until rst.
- halt_i at if_pc_o=0x10 -> if_valid_o=0 and state_o=HALT; 5 cycles idle with no change; redirect to 0x20 -> RUN, if_pc_o=0x20 valid.
- Redirect to 0xFFFF_FFFC, then run -> if_pc_o=0xFFFF_FFFC, then 0x0, then 0x4 with no fault; async rst pulse mid-stream -> outputs return to reset values immediately.

Source files
------------

// File: rtl/pc_fetch_sequencer_pkg.sv
// fetch_pkg: shared definitions for the PC / fetch-sequencing stage.
//   fetch_state_e        : FSM state encoding (RUN/HALT/FAULT; 2'd3 is illegal)
//   INSTR_BYTES          : bytes per instruction (PC increment)
//   RESET_VECTOR_DEFAULT : default byte address loaded into the PC on reset
//   is_aligned()         : true when a byte address is instruction-aligned
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    localparam int          INSTR_BYTES          = 4;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    function automatic logic is_aligned(input logic [1:0] addr_lsbs);
        return (addr_lsbs == 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Bundle between the fetch sequencer and its environment.
//   master : the control side (pipeline / bench) driving stall, redirect, halt
//            and observing the memory address, tag, valid, fault and state.
//   slave  : the fetch sequencer itself.
interface pc_fetch_sequencer_if #(
    parameter int XLEN    = 32,
    parameter int IMEM_AW = 32
);
    logic               stall_i;
    logic               redirect_valid_i;
    logic [XLEN-1:0]    redirect_target_i;
    logic               halt_i;
    logic [IMEM_AW-1:0] imem_addr_o;
    logic [XLEN-1:0]    if_pc_o;
    logic               if_valid_o;
    logic               fault_o;
    logic [1:0]         state_o;

    modport master (
        output stall_i, redirect_valid_i, redirect_target_i, halt_i,
        input  imem_addr_o, if_pc_o, if_valid_o, fault_o, state_o
    );

    modport slave (
        input  stall_i, redirect_valid_i, redirect_target_i, halt_i,
        output imem_addr_o, if_pc_o, if_valid_o, fault_o, state_o
    );
endinterface

// File: rtl/pc_fetch_sequencer_next_pc_mux.sv
// next_pc_mux: combinational selection of the byte address presented to the
// synchronous-read instruction memory, converted to a word index.
//   i_state           : current sequencer state
//   i_pc              : next address to fetch
//   i_if_pc           : address the memory sampled at the last edge
//   i_redirect_valid  : redirect request
//   i_redirect_target : redirect byte address
//   i_stall           : downstream not ready
//   o_imem_addr       : word index (byte address >> 2, zero-extended)
module next_pc_mux
    import fetch_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int IMEM_AW = 32
) (
    input  fetch_state_e       i_state,
    input  logic [XLEN-1:0]    i_pc,
    input  logic [XLEN-1:0]    i_if_pc,
    input  logic               i_redirect_valid,
    input  logic [XLEN-1:0]    i_redirect_target,
    input  logic               i_stall,
    output logic [IMEM_AW-1:0] o_imem_addr
);
    logic [XLEN-1:0] w_sel_addr;
    logic [XLEN-1:0] w_word;

    always_comb begin
        w_sel_addr = i_pc;
        if (i_state == ST_FAULT) begin
            w_sel_addr = i_pc;
        end else if (i_redirect_valid && is_aligned(i_redirect_target[1:0])) begin
            w_sel_addr = i_redirect_target;
        end else if (i_stall || (i_state == ST_HALT)) begin
            // Re-read the held address so the memory output stays stable.
            w_sel_addr = i_if_pc;
        end else begin
            w_sel_addr = i_pc;
        end
    end

    assign w_word      = w_sel_addr >> 2;
    assign o_imem_addr = IMEM_AW'(w_word);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the PC, drives the instruction-memory word address
// and tags the memory's (one-cycle-late) output with its PC and a valid bit.
// Handles sequential fetch, stall, zero-bubble redirect, halt/resume and a
// sticky misaligned-redirect fault.
//   clk, rst : clock; asynchronous active-high reset
//   bus      : slave side of pc_fetch_sequencer_if (stall/redirect/halt in;
//              imem_addr, if_pc, if_valid, fault, state out)
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | fetching; stall holds, aligned redirect reloads, halt_i -> HALT
// HALT  | idle, if_valid low; only a redirect leaves (aligned -> RUN)
// FAULT | misaligned redirect seen; everything frozen until rst
// 2'd3  | illegal; recovers to FAULT
module pc_fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
    parameter int              IMEM_AW      = 32
) (
    input  logic               clk,
    input  logic               rst,
    pc_fetch_sequencer_if.slave bus
);
    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_if_pc;
    logic            r_if_valid;
    logic            r_fault;

    fetch_state_e    w_nxt_state;
    logic [XLEN-1:0] w_nxt_pc;
    logic [XLEN-1:0] w_nxt_if_pc;
    logic            w_nxt_if_valid;
    logic            w_nxt_fault;

    logic            w_redir;
    logic            w_redir_ok;
    logic            w_redir_bad;
    logic [XLEN-1:0] w_pc_inc;
    logic [XLEN-1:0] w_tgt_inc;

    assign w_redir     = bus.redirect_valid_i;
    assign w_redir_ok  = w_redir && is_aligned(bus.redirect_target_i[1:0]);
    assign w_redir_bad = w_redir && !is_aligned(bus.redirect_target_i[1:0]);
    // Wraps modulo 2^XLEN by construction.
    assign w_pc_inc    = r_pc + XLEN'(INSTR_BYTES);
    assign w_tgt_inc   = bus.redirect_target_i + XLEN'(INSTR_BYTES);

    next_pc_mux #(
        .XLEN    (XLEN),
        .IMEM_AW (IMEM_AW)
    ) u_next_pc_mux (
        .i_state           (r_state),
        .i_pc              (r_pc),
        .i_if_pc           (r_if_pc),
        .i_redirect_valid  (bus.redirect_valid_i),
        .i_redirect_target (bus.redirect_target_i),
        .i_stall           (bus.stall_i),
        .o_imem_addr       (bus.imem_addr_o)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_VECTOR;
            r_if_pc    <= RESET_VECTOR;
            r_if_valid <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_pc       <= w_nxt_pc;
            r_if_pc    <= w_nxt_if_pc;
            r_if_valid <= w_nxt_if_valid;
            r_fault    <= w_nxt_fault;
        end
    end

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_pc       = r_pc;
        w_nxt_if_pc    = r_if_pc;
        w_nxt_if_valid = r_if_valid;
        w_nxt_fault    = r_fault;

        case (r_state)
            ST_RUN: begin
                if (w_redir_bad) begin
                    w_nxt_state    = ST_FAULT;
                    w_nxt_fault    = 1'b1;
                    w_nxt_if_valid = 1'b0;
                end else if (w_redir_ok) begin
                    // Zero-bubble: target was already on imem_addr this cycle.
                    w_nxt_if_pc    = bus.redirect_target_i;
                    w_nxt_pc       = w_tgt_inc;
                    w_nxt_if_valid = 1'b1;
                end else if (bus.halt_i) begin
                    w_nxt_state    = ST_HALT;
                    w_nxt_if_valid = 1'b0;
                end else if (!bus.stall_i) begin
                    w_nxt_if_pc    = r_pc;
                    w_nxt_pc       = w_pc_inc;
                    w_nxt_if_valid = 1'b1;
                end
            end
            ST_HALT: begin
                if (w_redir_bad) begin
                    w_nxt_state    = ST_FAULT;
                    w_nxt_fault    = 1'b1;
                    w_nxt_if_valid = 1'b0;
                end else if (w_redir_ok) begin
                    w_nxt_state    = ST_RUN;
                    w_nxt_if_pc    = bus.redirect_target_i;
                    w_nxt_pc       = w_tgt_inc;
                    w_nxt_if_valid = 1'b1;
                end
            end
            ST_FAULT: begin
                w_nxt_if_valid = 1'b0;
            end
            default: begin
                w_nxt_state    = ST_FAULT;
                w_nxt_fault    = 1'b1;
                w_nxt_if_valid = 1'b0;
            end
        endcase
    end

    assign bus.if_pc_o    = r_if_pc;
    assign bus.if_valid_o = r_if_valid;
    assign bus.fault_o    = r_fault;
    assign bus.state_o    = r_state;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pc_fetch_sequencer_if #(.XLEN(32), .IMEM_AW(32)) bus();

    pc_fetch_sequencer #(
        .XLEN         (32),
        .RESET_VECTOR (RV),
        .IMEM_AW      (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: architectural view of the fetch stage.
    // Expected post-edge outputs and the current memory address are queued.
    typedef struct {
        logic [31:0] if_pc;
        logic        v;
        logic        f;
        logic [1:0]  st;
    } reg_exp_t;

    reg_exp_t    q_reg[$];
    logic [31:0] q_addr[$];

    logic [31:0] m_pc, m_ifpc;
    bit          m_v, m_f;
    int          m_st;   // 0 running, 1 halted, 2 faulted

    task automatic model_reset();
        m_pc = RV; m_ifpc = RV; m_v = 0; m_f = 0; m_st = 0;
    endtask

    task automatic model_step(input bit s, input bit rv, input logic [31:0] t,
                              input bit h, output logic [31:0] addr);
        bit ok;
        ok = (t % 4) == 0;
        if (m_st == 2)            addr = m_pc / 4;
        else if (rv && ok)        addr = t / 4;
        else if (s || m_st == 1)  addr = m_ifpc / 4;
        else                      addr = m_pc / 4;

        if (m_st == 2) begin
            m_v = 0;
        end else if (rv && !ok) begin
            m_st = 2; m_f = 1; m_v = 0;
        end else if (rv) begin
            m_st = 0; m_ifpc = t; m_pc = t + 32'd4; m_v = 1;
        end else if (m_st == 1) begin
            // halted: nothing but a redirect matters
        end else if (h) begin
            m_st = 1; m_v = 0;
        end else if (!s) begin
            m_ifpc = m_pc; m_pc = m_pc + 32'd4; m_v = 1;
        end
    endtask

    task automatic drive(input bit s, input bit rv, input logic [31:0] t, input bit h);
        bus.stall_i           = s;
        bus.redirect_valid_i  = rv;
        bus.redirect_target_i = t;
        bus.halt_i            = h;
    endtask

    task automatic cyc(input bit s, input bit rv, input logic [31:0] t, input bit h);
        logic [31:0] a;
        @(posedge clk);
        #2;
        rst = 1'b0;
        drive(s, rv, t, h);
        model_step(s, rv, t, h, a);
        q_addr.push_back(a);
        q_reg.push_back('{m_ifpc, m_v, m_f, 2'(m_st)});
    endtask

    // Reset asserted mid-cycle; outputs must change without waiting for an edge.
    task automatic rst_cyc();
        @(posedge clk);
        #2;
        rst = 1'b1;
        drive(0, 0, 32'h0, 0);
        model_reset();
        #1;
        chk("async_rst_if_pc", bus.if_pc_o, RV);
        chk("async_rst_valid", 32'(bus.if_valid_o), 32'd0);
        chk("async_rst_fault", 32'(bus.fault_o), 32'd0);
        chk("async_rst_state", 32'(bus.state_o), 32'd0);
        chk("async_rst_addr", bus.imem_addr_o, RV >> 2);
        q_addr.push_back(RV >> 2);
        q_reg.push_back('{RV, 1'b0, 1'b0, 2'd0});
    endtask

    initial begin : mon_reg
        reg_exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_reg.size() > 0) begin
                e = q_reg.pop_front();
                chk("if_pc", bus.if_pc_o, e.if_pc);
                chk("if_valid", 32'(bus.if_valid_o), 32'(e.v));
                chk("fault", 32'(bus.fault_o), 32'(e.f));
                chk("state", 32'(bus.state_o), 32'(e.st));
            end
        end
    end

    initial begin : mon_addr
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (q_addr.size() > 0) begin
                a = q_addr.pop_front();
                chk("imem_addr", bus.imem_addr_o, a);
            end
        end
    end

    initial begin : stim
        bit          s, rv, h;
        logic [31:0] t;
        int          r;
        drive(0, 0, 32'h0, 0);
        model_reset();

        repeat (3) rst_cyc();
        // sequential run up to if_pc = 0x8
        repeat (3) cyc(0, 0, 32'h0, 0);
        // stall three cycles, then release
        repeat (3) cyc(1, 0, 32'h0, 0);
        repeat (2) cyc(0, 0, 32'h0, 0);
        // redirect to 0x100 overriding a stall
        cyc(1, 1, 32'h100, 0);
        repeat (2) cyc(0, 0, 32'h0, 0);
        // misaligned redirect -> sticky fault; aligned redirect does not clear it
        cyc(0, 1, 32'h102, 0);
        repeat (2) cyc(0, 0, 32'h0, 0);
        cyc(0, 1, 32'h0, 0);
        repeat (2) cyc(1, 0, 32'h0, 1);
        repeat (2) rst_cyc();
        // run to if_pc = 0x10, halt, idle, resume by redirect
        repeat (5) cyc(0, 0, 32'h0, 0);
        cyc(0, 0, 32'h0, 1);
        cyc(0, 0, 32'h0, 0);
        cyc(1, 0, 32'h0, 0);
        cyc(0, 0, 32'h0, 1);
        cyc(1, 0, 32'h0, 1);
        cyc(0, 0, 32'h0, 0);
        cyc(0, 1, 32'h20, 0);
        repeat (2) cyc(0, 0, 32'h0, 0);
        // PC wrap at the top of the address space
        cyc(0, 1, 32'hFFFF_FFFC, 0);
        repeat (3) cyc(0, 0, 32'h0, 0);
        rst_cyc();

        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2 || (m_st == 2 && r < 12)) begin
                rst_cyc();
            end else begin
                s  = ($urandom_range(0, 3) == 0);
                rv = ($urandom_range(0, 9) == 0);
                h  = ($urandom_range(0, 19) == 0);
                t  = $urandom & ~32'd3;
                if ($urandom_range(0, 24) == 0) t[1:0] = 2'($urandom_range(1, 3));
                if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFFC;
                cyc(s, rv, t, h);
            end
        end

        @(posedge clk);
        #2;
        drive(0, 0, 32'h0, 0);
        repeat (2) @(negedge clk);
        chk("queue_drain", 32'(q_reg.size() + q_addr.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
